// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state/owner encodings and configuration check for mem_bus_arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } arb_owner_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  function automatic bit lat_cfg_ok(input int lat, input int cw);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX) && (lat < (1 << cw));
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports and the Bridge data port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_we;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_stall;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [31:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    input  s_rdata,
    output m0_rdata, m0_stall, m1_ack, m1_rdata,
    output s_addr, s_we, s_wdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    output m1_req, m1_addr, m1_we, m1_wdata,
    output s_rdata,
    input  m0_rdata, m0_stall, m1_ack, m1_rdata,
    input  s_addr, s_we, s_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the master that was not
// granted last wins.
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  arb_owner_e i_last_gnt,
  output logic       o_gnt_valid,
  output arb_owner_e o_gnt_id
);

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_id    = OWN_M0;
    case (i_req)
      2'b01:   o_gnt_id = OWN_M0;
      2'b10:   o_gnt_id = OWN_M1;
      2'b11:   o_gnt_id = (i_last_gnt == OWN_M1) ? OWN_M0 : OWN_M1;
      default: o_gnt_id = OWN_M0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the Bridge data port with a fixed LAT-cycle slot.
// Optional ARB_PERF_CNT_EN adds perf_m0_wait / perf_m1_slots counters.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LAT = 1,
  parameter int CW  = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_m0_wait,
  output logic [31:0] perf_m1_slots,
`endif
  mem_bus_arbiter_if.slave bus
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  generate
    if (!lat_cfg_ok(LAT, CW)) begin : g_bad_cfg
      $error("mem_bus_arbiter: LAT must be 1..15 and below 2**CW");
    end
  endgenerate

  arb_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  arb_owner_e    r_owner, w_owner_nxt;
  arb_owner_e    r_last_gnt, w_last_gnt_nxt;
  logic [31:0]   r_m1_rdata;

  logic          w_gnt_valid;
  arb_owner_e    w_gnt_id;
  arb_owner_e    w_sel;
  logic          w_drive;
  logic          w_done;
  logic          w_owner_req;
  logic          w_own_m1;
  logic          w_m0_done;
  logic          w_m1_done;

  arb_rr2 u_rr2 (
    .i_req       ({bus.m1_req, bus.m0_req}),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_owner_req = (r_owner == OWN_M1) ? bus.m1_req : bus.m0_req;

  // While cpu_rst is high the bus stays quiet so a slot cut short never strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_nxt    = r_owner;
    w_last_gnt_nxt = r_last_gnt;
    w_sel          = OWN_M0;
    w_drive        = 1'b0;
    w_done         = 1'b0;
    if (cpu_rst) begin
      w_state_nxt = ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_valid) begin
            w_drive        = 1'b1;
            w_sel          = w_gnt_id;
            w_last_gnt_nxt = w_gnt_id;
            if (LAT == 1) begin
              w_done = 1'b1;
            end else begin
              w_state_nxt = ARB_BUSY;
              w_cnt_nxt   = CNT_LOAD;
              w_owner_nxt = w_gnt_id;
            end
          end else begin
            w_drive = 1'b0;
          end
        end
        ARB_BUSY: begin
          w_drive   = 1'b1;
          w_sel     = r_owner;
          w_cnt_nxt = r_cnt - CNT_LAST;
          if (!w_owner_req) begin
            w_state_nxt = ARB_IDLE;
            w_cnt_nxt   = {CW{1'b0}};
          end else if (r_cnt == CNT_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = ARB_IDLE;
          end else begin
            w_state_nxt = ARB_BUSY;
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  assign w_own_m1  = (w_sel == OWN_M1);
  assign w_m0_done = w_done & ~w_own_m1;
  assign w_m1_done = w_done & w_own_m1;

  assign bus.s_addr   = w_drive ? (w_own_m1 ? bus.m1_addr : bus.m0_addr) : 32'h0000_0000;
  assign bus.s_wdata  = w_drive ? (w_own_m1 ? bus.m1_wdata : bus.m0_wdata) : 32'h0000_0000;
  assign bus.s_we     = w_done & (w_own_m1 ? bus.m1_we : bus.m0_we);
  assign bus.m0_stall = bus.m0_req & ~w_m0_done & ~cpu_rst;
  assign bus.m0_rdata = w_m0_done ? bus.s_rdata : 32'h0000_0000;
  assign bus.m1_ack   = w_m1_done;
  assign bus.m1_rdata = r_m1_rdata;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state    <= ARB_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_owner    <= OWN_M0;
      r_last_gnt <= OWN_M1;
      r_m1_rdata <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      if (w_m1_done) begin
        r_m1_rdata <= bus.s_rdata;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_m0_wait;
  logic [31:0] r_perf_m1_slots;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_perf_m0_wait  <= 32'h0000_0000;
      r_perf_m1_slots <= 32'h0000_0000;
    end else begin
      if (bus.m0_stall) begin
        r_perf_m0_wait <= r_perf_m0_wait + 32'd1;
      end
      if (w_m1_done) begin
        r_perf_m1_slots <= r_perf_m1_slots + 32'd1;
      end
    end
  end

  assign perf_m0_wait  = r_perf_m0_wait;
  assign perf_m1_slots = r_perf_m1_slots;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: one instance per LAT value (1..4),
// a vector table for LAT=1 and scripted multi-cycle sequences for the rest.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst4;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arbiter_if if1 ();
  mem_bus_arbiter_if if2 ();
  mem_bus_arbiter_if if3 ();
  mem_bus_arbiter_if if4 ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] pw [4];
  logic [31:0] ps [4];
`endif

  mem_bus_arbiter #(.LAT(1), .CW(4)) u_l1 (
    .cpu_clk(clk), .cpu_rst(rst),
`ifdef ARB_PERF_CNT_EN
    .perf_m0_wait(pw[0]), .perf_m1_slots(ps[0]),
`endif
    .bus(if1));
  mem_bus_arbiter #(.LAT(2), .CW(4)) u_l2 (
    .cpu_clk(clk), .cpu_rst(rst),
`ifdef ARB_PERF_CNT_EN
    .perf_m0_wait(pw[1]), .perf_m1_slots(ps[1]),
`endif
    .bus(if2));
  mem_bus_arbiter #(.LAT(3), .CW(4)) u_l3 (
    .cpu_clk(clk), .cpu_rst(rst),
`ifdef ARB_PERF_CNT_EN
    .perf_m0_wait(pw[2]), .perf_m1_slots(ps[2]),
`endif
    .bus(if3));
  mem_bus_arbiter #(.LAT(4), .CW(4)) u_l4 (
    .cpu_clk(clk), .cpu_rst(rst4),
`ifdef ARB_PERF_CNT_EN
    .perf_m0_wait(pw[3]), .perf_m1_slots(ps[3]),
`endif
    .bus(if4));

  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic [31:0] s_rdata;
    logic [31:0] e_s_addr;
    logic        e_s_we;
    logic [31:0] e_s_wdata;
    logic        e_stall;
    logic [31:0] e_m0_rdata;
    logic        e_ack;
    logic [31:0] e_m1_rdata;
  } vec_t;

  vec_t tv [10];

  function automatic vec_t mk(
    input logic m0r, input logic [31:0] m0a, input logic m0w, input logic [31:0] m0d,
    input logic m1r, input logic [31:0] m1a, input logic m1w, input logic [31:0] m1d,
    input logic [31:0] srd,
    input logic [31:0] ea, input logic ewe, input logic [31:0] ed,
    input logic est, input logic [31:0] er0, input logic eak, input logic [31:0] er1);
    vec_t v;
    v.m0_req = m0r; v.m0_addr = m0a; v.m0_we = m0w; v.m0_wdata = m0d;
    v.m1_req = m1r; v.m1_addr = m1a; v.m1_we = m1w; v.m1_wdata = m1d;
    v.s_rdata = srd;
    v.e_s_addr = ea; v.e_s_we = ewe; v.e_s_wdata = ed;
    v.e_stall = est; v.e_m0_rdata = er0; v.e_ack = eak; v.e_m1_rdata = er1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.m0_req = 1'b0; if1.m0_addr = 32'h0; if1.m0_we = 1'b0; if1.m0_wdata = 32'h0;
    if1.m1_req = 1'b0; if1.m1_addr = 32'h0; if1.m1_we = 1'b0; if1.m1_wdata = 32'h0;
    if1.s_rdata = 32'h0;
    if2.m0_req = 1'b0; if2.m0_addr = 32'h0; if2.m0_we = 1'b0; if2.m0_wdata = 32'h0;
    if2.m1_req = 1'b0; if2.m1_addr = 32'h0; if2.m1_we = 1'b0; if2.m1_wdata = 32'h0;
    if2.s_rdata = 32'h0;
    if3.m0_req = 1'b0; if3.m0_addr = 32'h0; if3.m0_we = 1'b0; if3.m0_wdata = 32'h0;
    if3.m1_req = 1'b0; if3.m1_addr = 32'h0; if3.m1_we = 1'b0; if3.m1_wdata = 32'h0;
    if3.s_rdata = 32'h0;
    if4.m0_req = 1'b0; if4.m0_addr = 32'h0; if4.m0_we = 1'b0; if4.m0_wdata = 32'h0;
    if4.m1_req = 1'b0; if4.m1_addr = 32'h0; if4.m1_we = 1'b0; if4.m1_wdata = 32'h0;
    if4.s_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_wait;
    int exp_slots;
    exp_wait  = 0;
    exp_slots = 0;

    // LAT=1 vectors: last_gnt starts at M1, so M0 wins the first tie, then strict alternation.
    tv[0] = mk(1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        32'h0,
               32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    tv[1] = mk(1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 1'b1, 32'h300, 1'b0, 32'h0,        32'hA5A5A5A5,
               32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h0);
    tv[2] = mk(1'b1, 32'h104, 1'b0, 32'h0,        1'b1, 32'h300, 1'b0, 32'h0,        32'h11111111,
               32'h300, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0);
    tv[3] = mk(1'b1, 32'h104, 1'b0, 32'h0,        1'b1, 32'h304, 1'b1, 32'hCAFEF00D, 32'h22222222,
               32'h104, 1'b0, 32'h0,        1'b0, 32'h22222222, 1'b0, 32'h11111111);
    tv[4] = mk(1'b1, 32'h108, 1'b0, 32'h0,        1'b1, 32'h304, 1'b1, 32'hCAFEF00D, 32'h33333333,
               32'h304, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0,        1'b1, 32'h11111111);
    tv[5] = mk(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'h30C, 1'b0, 32'h0,        32'h44444444,
               32'h30C, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h33333333);
    tv[6] = mk(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'h310, 1'b0, 32'h0,        32'h55555555,
               32'h310, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h44444444);
    tv[7] = mk(1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,   1'b0, 32'h0,        32'h0,
               32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h55555555);
    tv[8] = mk(1'b1, 32'h108, 1'b0, 32'h0,        1'b1, 32'h314, 1'b0, 32'h77777777, 32'h66666666,
               32'h314, 1'b0, 32'h77777777, 1'b1, 32'h0,        1'b1, 32'h55555555);
    tv[9] = mk(1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        32'h0,
               32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h66666666);

    rst = 1'b1;
    rst4 = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset s_addr",   if1.s_addr,   32'h0);
    chk("reset s_we",     if1.s_we,     32'h0);
    chk("reset s_wdata",  if1.s_wdata,  32'h0);
    chk("reset m0_stall", if1.m0_stall, 32'h0);
    chk("reset m1_ack",   if1.m1_ack,   32'h0);
    chk("reset m0_rdata", if1.m0_rdata, 32'h0);
    chk("reset m1_rdata", if1.m1_rdata, 32'h0);
    next_cyc();
    rst = 1'b0;
    rst4 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if1.m0_req = tv[i].m0_req; if1.m0_addr = tv[i].m0_addr;
      if1.m0_we = tv[i].m0_we;   if1.m0_wdata = tv[i].m0_wdata;
      if1.m1_req = tv[i].m1_req; if1.m1_addr = tv[i].m1_addr;
      if1.m1_we = tv[i].m1_we;   if1.m1_wdata = tv[i].m1_wdata;
      if1.s_rdata = tv[i].s_rdata;
      exp_wait  += int'(tv[i].e_stall);
      exp_slots += int'(tv[i].e_ack);
      @(negedge clk);
      chk($sformatf("l1 v%0d s_addr", i),   if1.s_addr,   tv[i].e_s_addr);
      chk($sformatf("l1 v%0d s_we", i),     if1.s_we,     tv[i].e_s_we);
      chk($sformatf("l1 v%0d s_wdata", i),  if1.s_wdata,  tv[i].e_s_wdata);
      chk($sformatf("l1 v%0d m0_stall", i), if1.m0_stall, tv[i].e_stall);
      chk($sformatf("l1 v%0d m0_rdata", i), if1.m0_rdata, tv[i].e_m0_rdata);
      chk($sformatf("l1 v%0d m1_ack", i),   if1.m1_ack,   tv[i].e_ack);
      chk($sformatf("l1 v%0d m1_rdata", i), if1.m1_rdata, tv[i].e_m1_rdata);
      next_cyc();
    end
`ifdef ARB_PERF_CNT_EN
    chk("l1 perf_m0_wait",  pw[0], 32'(exp_wait));
    chk("l1 perf_m1_slots", ps[0], 32'(exp_slots));
`endif

    // LAT=2: M1 write in progress when M0 arrives; M0 waits, then gets its own slot.
    if2.m1_req = 1'b1; if2.m1_addr = 32'h400; if2.m1_we = 1'b1; if2.m1_wdata = 32'h0BADF00D;
    if2.s_rdata = 32'h0F0F0F0F;
    @(negedge clk);
    chk("l2 c1 s_addr", if2.s_addr, 32'h400);
    chk("l2 c1 s_we",   if2.s_we,   32'h0);
    chk("l2 c1 m1_ack", if2.m1_ack, 32'h0);
    next_cyc();
    if2.m0_req = 1'b1; if2.m0_addr = 32'h500; if2.m0_we = 1'b1; if2.m0_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("l2 c2 s_we",     if2.s_we,     32'h1);
    chk("l2 c2 s_wdata",  if2.s_wdata,  32'h0BADF00D);
    chk("l2 c2 m1_ack",   if2.m1_ack,   32'h1);
    chk("l2 c2 m0_stall", if2.m0_stall, 32'h1);
    next_cyc();
    if2.m1_req = 1'b0;
    @(negedge clk);
    chk("l2 c3 s_addr",   if2.s_addr,   32'h500);
    chk("l2 c3 s_we",     if2.s_we,     32'h0);
    chk("l2 c3 m0_stall", if2.m0_stall, 32'h1);
    chk("l2 c3 m1_ack",   if2.m1_ack,   32'h0);
    next_cyc();
    @(negedge clk);
    chk("l2 c4 s_we",     if2.s_we,     32'h1);
    chk("l2 c4 s_wdata",  if2.s_wdata,  32'h5A5A5A5A);
    chk("l2 c4 m0_stall", if2.m0_stall, 32'h0);
    chk("l2 c4 m0_rdata", if2.m0_rdata, 32'h0F0F0F0F);
    next_cyc();
    if2.m0_req = 1'b0;
    @(negedge clk);
    chk("l2 c5 s_addr", if2.s_addr, 32'h0);
    chk("l2 c5 s_we",   if2.s_we,   32'h0);
    next_cyc();

    // LAT=3: M0 load stalls two cycles, completes in the third.
    if3.m0_req = 1'b1; if3.m0_addr = 32'h200; if3.s_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("l3 ld c%0d s_addr", i),   if3.s_addr,   32'h200);
      chk($sformatf("l3 ld c%0d m0_stall", i), if3.m0_stall, (i < 2) ? 32'h1 : 32'h0);
      chk($sformatf("l3 ld c%0d m0_rdata", i), if3.m0_rdata, (i < 2) ? 32'h0 : 32'h12345678);
      chk($sformatf("l3 ld c%0d s_we", i),     if3.s_we,     32'h0);
      next_cyc();
    end
    if3.m0_req = 1'b0;
    @(negedge clk);
    chk("l3 after m0_stall", if3.m0_stall, 32'h0);
    chk("l3 after m0_rdata", if3.m0_rdata, 32'h0);
    next_cyc();

    // LAT=3 abort: M0 store dropped after the grant cycle must not write.
    if3.m0_req = 1'b1; if3.m0_addr = 32'h210; if3.m0_we = 1'b1; if3.m0_wdata = 32'hABCDEF01;
    @(negedge clk);
    chk("l3 ab c0 m0_stall", if3.m0_stall, 32'h1);
    chk("l3 ab c0 s_we",     if3.s_we,     32'h0);
    next_cyc();
    if3.m0_req = 1'b0; if3.m0_we = 1'b0;
    @(negedge clk);
    chk("l3 ab c1 s_we",     if3.s_we,     32'h0);
    chk("l3 ab c1 m0_stall", if3.m0_stall, 32'h0);
    next_cyc();
    if3.m1_req = 1'b1; if3.m1_addr = 32'h220; if3.s_rdata = 32'h0C0FFEE0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("l3 m1 c%0d s_addr", i), if3.s_addr, 32'h220);
      chk($sformatf("l3 m1 c%0d m1_ack", i), if3.m1_ack, (i == 2) ? 32'h1 : 32'h0);
      next_cyc();
    end
    if3.m1_req = 1'b0;
    @(negedge clk);
    chk("l3 m1 m1_rdata", if3.m1_rdata, 32'h0C0FFEE0);
    chk("l3 m1 m1_ack",   if3.m1_ack,   32'h0);
    next_cyc();

    // LAT=4: complete an M1 read, then reset in the 2nd cycle of an M1 write slot.
    if4.m1_req = 1'b1; if4.m1_addr = 32'h600; if4.s_rdata = 32'h89ABCDEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("l4 rd c%0d m1_ack", i), if4.m1_ack, (i == 3) ? 32'h1 : 32'h0);
      next_cyc();
    end
    if4.m1_req = 1'b0;
    @(negedge clk);
    chk("l4 rd m1_rdata", if4.m1_rdata, 32'h89ABCDEF);
    next_cyc();
    if4.m1_req = 1'b1; if4.m1_addr = 32'h610; if4.m1_we = 1'b1; if4.m1_wdata = 32'h13579BDF;
    @(negedge clk);
    chk("l4 wr c0 s_addr", if4.s_addr, 32'h610);
    chk("l4 wr c0 s_we",   if4.s_we,   32'h0);
    next_cyc();
    rst4 = 1'b1;
    @(negedge clk);
    chk("l4 rst s_we",   if4.s_we,   32'h0);
    chk("l4 rst m1_ack", if4.m1_ack, 32'h0);
    next_cyc();
    rst4 = 1'b0; if4.m1_req = 1'b0; if4.m1_we = 1'b0;
    @(negedge clk);
    chk("l4 post s_addr",   if4.s_addr,   32'h0);
    chk("l4 post s_we",     if4.s_we,     32'h0);
    chk("l4 post m1_ack",   if4.m1_ack,   32'h0);
    chk("l4 post m1_rdata", if4.m1_rdata, 32'h0);
    next_cyc();
    if4.m0_req = 1'b1; if4.m0_addr = 32'h620;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("l4 m0 c%0d s_addr", i),   if4.s_addr,   32'h620);
      chk($sformatf("l4 m0 c%0d m0_stall", i), if4.m0_stall, (i < 3) ? 32'h1 : 32'h0);
      next_cyc();
    end
    if4.m0_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
